// File: rtl/alu_req_sequencer.sv
// -----------------------------------------------------------------------------
// alu_req_sequencer
//
// Shares one ALU (19-bit instruction, 16-bit result) between two requesters.
// One operation is in flight at a time: a requester is granted in IDLE, its
// instruction is driven onto alu_inst, the sequencer waits ALU_LATENCY edges,
// captures alu_r and presents it as a response tagged with the requester id.
//
// Arbitration: round-robin between requesters when both are valid (req0
// favoured out of reset). Defining ALU_SEQ_FIXED_PRIO_EN gives fixed
// priority instead: req0 always wins a tie and no round-robin pointer exists.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/inst/ready     requester 0 valid/ready handshake
//   req1_valid/inst/ready     requester 1 valid/ready handshake
//   alu_inst                  registered instruction to the ALU
//   alu_r                     ALU result
//   rsp_valid/ready/id/data   response handshake, requester id, ALU result
//   busy                      high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module alu_req_sequencer #(
  parameter int INST_W      = 19,
  parameter int DATA_W      = 16,
  parameter int ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [INST_W-1:0] req0_inst,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [INST_W-1:0] req1_inst,
  output logic              req1_ready,
  output logic [INST_W-1:0] alu_inst,
  input  logic [DATA_W-1:0] alu_r,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // The wait counter is 4 bits wide, so the latency is limited to 1..15.
  localparam logic [3:0] LAT_CNT = 4'(ALU_LATENCY);

  state_t      state;
  logic [3:0]  cnt;
  logic        grant;
  logic        any_valid;

`ifndef ALU_SEQ_FIXED_PRIO_EN
  logic        rr_ptr;
`endif

  // Grant selection: a lone valid requester wins; a tie goes to the arbiter.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_SEQ_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = rr_ptr;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  // Ready strobes are only offered in IDLE, to the granted requester.
  always_comb begin
    req0_ready = (state == IDLE) && any_valid && (grant == 1'b0);
    req1_ready = (state == IDLE) && any_valid && (grant == 1'b1);
  end

  // Sequencer FSM with registered ALU-side and response-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      alu_inst  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      cnt       <= 4'd0;
      busy      <= 1'b0;
`ifndef ALU_SEQ_FIXED_PRIO_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            // The granted requester is always ready here, so valid means accept.
            alu_inst <= grant ? req1_inst : req0_inst;
            rsp_id   <= grant;
            cnt      <= LAT_CNT;
            busy     <= 1'b1;
            state    <= EXEC;
`ifndef ALU_SEQ_FIXED_PRIO_EN
            rr_ptr   <= ~grant;
`endif
          end
        end
        EXEC: begin
          // alu_inst is held; the result is sampled once the count has drained.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_data  <= alu_r;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_req_sequencer
//
// Self-checking bench for alu_req_sequencer. Two instances: one with the
// default ALU latency (1) and one with latency 3. Each has an ALU stub that
// returns R = A + B after the configured latency. Directed scenarios are
// followed by a randomized run checked against a transaction-level model.
// Honours ALU_SEQ_FIXED_PRIO_EN for the expected arbitration outcome.
// -----------------------------------------------------------------------------
module tb_alu_req_sequencer;

  localparam int INST_W = 19;
  localparam int DATA_W = 16;
  localparam int LAT    = 1;
  localparam int LAT3   = 3;

`ifdef ALU_SEQ_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  logic [INST_W-1:0] req0_inst, req1_inst, alu_inst;
  logic [DATA_W-1:0] alu_r, rsp_data;
  logic              rsp_valid, rsp_ready, rsp_id, busy;

  logic              d3_req0_valid, d3_req1_valid, d3_req0_ready, d3_req1_ready;
  logic [INST_W-1:0] d3_req0_inst, d3_req1_inst, d3_alu_inst;
  logic [DATA_W-1:0] d3_alu_r, d3_rsp_data, d3_p1, d3_p2;
  logic              d3_rsp_valid, d3_rsp_ready, d3_rsp_id, d3_busy;

  int tests = 0;
  int fails = 0;

  alu_req_sequencer #(.INST_W(INST_W), .DATA_W(DATA_W), .ALU_LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_inst(req0_inst), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_inst(req1_inst), .req1_ready(req1_ready),
    .alu_inst(alu_inst), .alu_r(alu_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  alu_req_sequencer #(.INST_W(INST_W), .DATA_W(DATA_W), .ALU_LATENCY(LAT3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(d3_req0_valid), .req0_inst(d3_req0_inst), .req0_ready(d3_req0_ready),
    .req1_valid(d3_req1_valid), .req1_inst(d3_req1_inst), .req1_ready(d3_req1_ready),
    .alu_inst(d3_alu_inst), .alu_r(d3_alu_r),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_id(d3_rsp_id),
    .rsp_data(d3_rsp_data), .busy(d3_busy)
  );

  // ALU behaviour: R = A + B with A = inst[15:8], B = inst[7:0].
  function automatic logic [DATA_W-1:0] alu_sum(input logic [INST_W-1:0] inst);
    return 16'(inst[15:8]) + 16'(inst[7:0]);
  endfunction

  // ALU stubs: one-stage and three-stage result pipelines.
  always @(posedge clk) alu_r <= alu_sum(alu_inst);
  always @(posedge clk) begin
    d3_p1    <= alu_sum(d3_alu_inst);
    d3_p2    <= d3_p1;
    d3_alu_r <= d3_p2;
  end

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    d3_req0_valid = 1'b0; d3_req1_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (alu_inst !== 19'h0) begin fails++; $display("FAIL reset_alu_inst got %h exp 0", alu_inst); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    tests++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL reset_rsp_id got %b exp 0", rsp_id); end
    tests++; if (rsp_data !== 16'h0) begin fails++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    tests++; if (busy !== 1'b0 || d3_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b/%b exp 0/0", busy, d3_busy); end
    tests++; if ({req1_ready, req0_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got %b exp 00", {req1_ready, req0_ready}); end
  endtask

  task automatic test_single_op();
    int n;
    @(posedge clk); #1;
    rsp_ready = 1'b1; req0_valid = 1'b1; req0_inst = 19'h2555D;
    @(negedge clk);
    tests++; if ({req1_ready, req0_ready} !== 2'b01) begin fails++; $display("FAIL single_ready got %b exp 01", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    tests++; if (alu_inst !== 19'h2555D) begin fails++; $display("FAIL single_alu_inst got %h exp 2555d", alu_inst); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b exp 1", busy); end
    // n counts edges with the accept edge as edge 1.
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk);
      n++;
    end
    tests++; if (n != LAT + 2) begin fails++; $display("FAIL single_latency got %0d exp %0d", n, LAT + 2); end
    tests++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL single_rsp_id got %b exp 0", rsp_id); end
    tests++; if (rsp_data !== 16'h00B2) begin fails++; $display("FAIL single_rsp_data got %h exp 00b2", rsp_data); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_done got v=%b b=%b exp 0/0", rsp_valid, busy); end
    tests++; if (alu_inst !== 19'h2555D) begin fails++; $display("FAIL single_inst_hold got %h exp 2555d", alu_inst); end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    rsp_ready = 1'b0; req1_valid = 1'b1; req1_inst = {3'd5, 8'h12, 8'h34};
    @(posedge clk); #1;
    req1_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    req0_valid = 1'b1; req0_inst = {3'd1, 8'h01, 8'h01};
    req1_valid = 1'b1; req1_inst = {3'd2, 8'h02, 8'h02};
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'h0046 ||
          {req1_ready, req0_ready} !== 2'b00 || busy !== 1'b1) begin
        fails++;
        $display("FAIL backpressure_hold cyc %0d got v=%b id=%b d=%h rdy=%b busy=%b exp 1/1/0046/00/1",
                 i, rsp_valid, rsp_id, rsp_data, {req1_ready, req0_ready}, busy);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL backpressure_release got v=%b b=%b exp 0/0", rsp_valid, busy); end
  endtask

  task automatic test_contention();
    int n_acc, n_rsp, last_acc;
    logic exp_id;
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_inst = {3'd0, 8'd1, 8'd2};
    req1_valid = 1'b1; req1_inst = {3'd0, 8'd3, 8'd4};
    n_acc = 0; n_rsp = 0; last_acc = 0;
    for (int cyc = 0; cyc < 60 && n_rsp < 4; cyc++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        exp_id = FIXED ? 1'b0 : n_acc[0];
        tests++;
        if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
          fails++; $display("FAIL contention_grant acc %0d got %b exp id %0d", n_acc, {req1_ready, req0_ready}, exp_id);
        end
        if (n_acc > 0) begin
          tests++;
          if (cyc - last_acc != LAT + 3) begin
            fails++; $display("FAIL contention_spacing got %0d exp %0d", cyc - last_acc, LAT + 3);
          end
        end
        last_acc = cyc;
        n_acc++;
      end
      if (rsp_valid) begin
        exp_id = FIXED ? 1'b0 : n_rsp[0];
        tests++;
        if (rsp_id !== exp_id || rsp_data !== (exp_id ? 16'd7 : 16'd3)) begin
          fails++; $display("FAIL contention_rsp %0d got id=%b d=%h exp id=%b d=%h", n_rsp, rsp_id, rsp_data, exp_id, exp_id ? 16'd7 : 16'd3);
        end
        n_rsp++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests++; if (n_rsp != 4) begin fails++; $display("FAIL contention_count got %0d exp 4", n_rsp); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_exec();
    bit seen;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_inst = {3'd3, 8'h40, 8'h41};
    @(negedge clk);
    tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL midrst_accept got %b exp 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || alu_inst !== 19'h0 || busy !== 1'b0) begin
      fails++; $display("FAIL midrst_clear got v=%b inst=%h b=%b exp 0/0/0", rsp_valid, alu_inst, busy);
    end
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    tests++; if (seen) begin fails++; $display("FAIL midrst_no_rsp got response exp none"); end
  endtask

  task automatic test_latency3();
    int n;
    @(posedge clk); #1;
    d3_rsp_ready = 1'b1; d3_req1_valid = 1'b1; d3_req1_inst = {3'd0, 8'd10, 8'd20};
    @(negedge clk);
    tests++; if ({d3_req1_ready, d3_req0_ready} !== 2'b10) begin fails++; $display("FAIL lat3_ready got %b exp 10", {d3_req1_ready, d3_req0_ready}); end
    @(posedge clk); #1;
    d3_req1_valid = 1'b0;
    n = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (d3_rsp_valid) break;
      @(posedge clk);
      n++;
    end
    tests++; if (n != LAT3 + 2) begin fails++; $display("FAIL lat3_latency got %0d exp %0d", n, LAT3 + 2); end
    tests++; if (d3_rsp_id !== 1'b1 || d3_rsp_data !== 16'h001E) begin
      fails++; $display("FAIL lat3_rsp got id=%b d=%h exp 1/001e", d3_rsp_id, d3_rsp_data);
    end
    @(posedge clk); #1;
  endtask

  // Transaction-level model: an accept at cycle c makes the response visible
  // from cycle c+LAT+2; it stays until taken, and the next accept may happen
  // the cycle after it is taken.
  task automatic test_random();
    bit v0, v1, rr, g, idle, e_r0, e_r1, e_rv, m_inflight, m_pref, m_id;
    logic [INST_W-1:0] i0, i1;
    logic [DATA_W-1:0] m_data;
    int m_start, n_rsp;
    do_reset();
    v0 = 1'b0; v1 = 1'b0; i0 = '0; i1 = '0;
    m_inflight = 1'b0; m_pref = 1'b0; m_id = 1'b0; m_data = '0; m_start = 0; n_rsp = 0;
    for (int c = 0; c < 400; c++) begin
      if (v0) begin if ($urandom_range(0, 9) == 0) v0 = 1'b0; end
      else if ($urandom_range(0, 2) == 0) begin v0 = 1'b1; i0 = 19'($urandom); end
      if (v1) begin if ($urandom_range(0, 9) == 0) v1 = 1'b0; end
      else if ($urandom_range(0, 2) == 0) begin v1 = 1'b1; i1 = 19'($urandom); end
      rr = ($urandom_range(0, 3) != 0);
      req0_valid = v0; req0_inst = i0; req1_valid = v1; req1_inst = i1; rsp_ready = rr;

      idle = !m_inflight;
      if (v0 && v1) g = FIXED ? 1'b0 : m_pref;
      else g = v1;
      e_r0 = idle && v0 && !g;
      e_r1 = idle && v1 && g;
      e_rv = m_inflight && (c >= m_start);

      @(negedge clk);
      tests++;
      if ({req1_ready, req0_ready} !== {e_r1, e_r0} || rsp_valid !== e_rv || busy !== m_inflight) begin
        fails++;
        $display("FAIL random_ctrl c=%0d got rdy=%b v=%b b=%b exp rdy=%b v=%b b=%b",
                 c, {req1_ready, req0_ready}, rsp_valid, busy, {e_r1, e_r0}, e_rv, m_inflight);
      end
      if (e_rv) begin
        tests++;
        if (rsp_id !== m_id || rsp_data !== m_data) begin
          fails++; $display("FAIL random_rsp c=%0d got id=%b d=%h exp id=%b d=%h", c, rsp_id, rsp_data, m_id, m_data);
        end
      end

      if (e_r0 || e_r1) begin
        m_inflight = 1'b1;
        m_start    = c + LAT + 2;
        m_id       = g;
        m_data     = alu_sum(g ? i1 : i0);
        m_pref     = ~g;
        if (g) v1 = 1'b0; else v0 = 1'b0;
      end else if (e_rv && rr) begin
        m_inflight = 1'b0;
        n_rsp++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    tests++; if (n_rsp < 10) begin fails++; $display("FAIL random_activity got %0d responses exp >= 10", n_rsp); end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_inst = '0; req1_valid = 1'b0; req1_inst = '0; rsp_ready = 1'b0;
    d3_req0_valid = 1'b0; d3_req0_inst = '0; d3_req1_valid = 1'b0; d3_req1_inst = '0; d3_rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_backpressure();
    test_contention();
    test_reset_mid_exec();
    test_latency3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "timeout");
  end

endmodule
